parity_accumulator: RTL and testbench

Streaming, parametrised parity unit: the multi-bit, sequential successor to the team's two-input XOR cell. It XOR-reduces each accepted WIDTH-bit word and accumulates parity across a frame of words delimited by `in_last`. It emits one parity result per frame over a valid/ready handshake, together with the frame word count. It sits between a word-stream source and any framing/check logic downstream.

---
 rtl/parity_accumulator.sv | 93 +++++++++
 tb/tb_parity_accumulator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_accumulator.sv
// Streaming parity unit: XOR-accumulates accepted words into a frame result with word count.
// Optional PARITY_CHECK_EN adds exp_par/par_err comparison against an expected frame parity.
module parity_accumulator #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16,
  localparam int CW       = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             par_valid,
  output logic             par_out,
  output logic [CW-1:0]    par_count,
  output logic             par_trunc,
  input  logic             par_ready,
`ifdef PARITY_CHECK_EN
  input  logic             exp_par,
  output logic             par_err,
`endif
  output logic             state_dbg
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            acc;
  logic            acc_nx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic            accept;
  logic            take;
  logic            closing;

  // Handshakes: a word moves when in_valid & in_ready; a result moves when
  // par_valid & par_ready. In HOLD a word is only taken alongside the result,
  // so the single result register is never overwritten before it is consumed.
  assign in_ready  = ~rst & ((state == ACCUM) | par_ready);
  assign par_valid = (state == HOLD);
  assign state_dbg = state;

  assign accept  = in_valid & in_ready;
  assign take    = par_valid & par_ready;
  assign acc_nx  = acc ^ (^in_data);
  assign cnt_inc = cnt + CW'(1);
  assign closing = accept & (in_last | (cnt_inc == CW'(MAX_WORDS)));

  always_comb begin
    state_nx = state;
    case (state)
      ACCUM: if (closing) state_nx = HOLD;
      HOLD:  if (take)    state_nx = closing ? HOLD : ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= 1'b0;
      cnt       <= '0;
      par_out   <= 1'b0;
      par_count <= '0;
      par_trunc <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_err   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (closing) begin
        // acc/cnt restart so a word accepted together with a take opens a fresh frame
        acc       <= 1'b0;
        cnt       <= '0;
        par_out   <= acc_nx;
        par_count <= cnt_inc;
        par_trunc <= ~in_last;
`ifdef PARITY_CHECK_EN
        par_err   <= acc_nx ^ exp_par;
`endif
      end else if (accept) begin
        acc <= acc_nx;
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_parity_accumulator.sv
// Directed plus randomised bench for parity_accumulator; a negedge monitor keeps a
// result scoreboard. Define PARITY_CHECK_EN to also cover exp_par/par_err.
module tb_parity_accumulator;

  localparam int WIDTH     = 8;
  localparam int MAX_WORDS = 16;
  localparam int CW        = $clog2(MAX_WORDS + 1);
  localparam int W         = CW + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             par_valid;
  logic             par_out;
  logic [CW-1:0]    par_count;
  logic             par_trunc;
  logic             par_ready = 1'b0;
  logic             state_dbg;
`ifdef PARITY_CHECK_EN
  logic             exp_par = 1'b0;
  logic             par_err;
`endif

  int errors = 0;
  int checks = 0;

  // scoreboard entry: {trunc, count, parity}
  logic [W-1:0] exp_q[$];
  logic         mon_en = 1'b0;
  logic         m_hold = 1'b0;
  logic         m_acc = 1'b0;
  int           m_cnt = 0;
  int           m_accepted = 0;

  parity_accumulator #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .par_valid(par_valid), .par_out(par_out), .par_count(par_count),
    .par_trunc(par_trunc), .par_ready(par_ready),
`ifdef PARITY_CHECK_EN
    .exp_par(exp_par), .par_err(par_err),
`endif
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver: present one word and hold it until accepted
  task automatic send_word(input logic [WIDTH-1:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic p, input int c, input logic t);
    check({tag, "_valid"}, {31'd0, par_valid}, 32'd1);
    check({tag, "_par"},   {31'd0, par_out},   {31'd0, p});
    check({tag, "_count"}, {{(32-CW){1'b0}}, par_count}, c);
    check({tag, "_trunc"}, {31'd0, par_trunc}, {31'd0, t});
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic exp_rdy;
    logic take;
    logic next_hold;
    logic [W-1:0] e;
    if (mon_en) begin
      exp_rdy = !rst && (!m_hold || par_ready);
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      check("par_valid", {31'd0, par_valid}, {31'd0, m_hold});
      take = m_hold && par_ready;
      if (m_hold) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q[0];
          check("sb_par",   {31'd0, par_out},   {31'd0, e[0]});
          check("sb_count", {{(32-CW){1'b0}}, par_count}, {{(32-CW){1'b0}}, e[CW:1]});
          check("sb_trunc", {31'd0, par_trunc}, {31'd0, e[W-1]});
          if (take) void'(exp_q.pop_front());
        end
      end
      if (rst) begin
        m_hold = 1'b0;
        m_acc  = 1'b0;
        m_cnt  = 0;
        exp_q.delete();
      end else begin
        next_hold = take ? 1'b0 : m_hold;
        if (in_valid && exp_rdy) begin
          m_acc = m_acc ^ (^in_data);
          m_cnt++;
          m_accepted++;
          if (in_last || m_cnt == MAX_WORDS) begin
            exp_q.push_back({~in_last, m_cnt[CW-1:0], m_acc});
            next_hold = 1'b1;
            m_acc = 1'b0;
            m_cnt = 0;
          end
        end
        m_hold = next_hold;
      end
    end
  end

  initial begin
    int base;
    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_par_valid", {31'd0, par_valid}, 32'd0);
    check("rst_par_out",   {31'd0, par_out},   32'd0);
    check("rst_par_count", {{(32-CW){1'b0}}, par_count}, 32'd0);
    check("rst_par_trunc", {31'd0, par_trunc}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    mon_en = 1'b1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // basic frame, result held downstream
    par_ready = 1'b0;
    send_word(8'h01, 1'b0);
    send_word(8'h03, 1'b0);
    send_word(8'hFF, 1'b1);
    check_result("frame3", 1'b1, 3, 1'b0);

    // back-pressure: offered words must not be accepted
    in_valid = 1'b1;
    in_data  = 8'hAA;
    in_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check_result("hold", 1'b1, 3, 1'b0);
    end
    @(posedge clk);
    #1;
    in_data   = 8'h80;
    in_last   = 1'b1;
    par_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_result("take_accept", 1'b1, 1, 1'b0);

    // truncation at MAX_WORDS, remainder forms next frame
    for (int i = 0; i < 16; i++) send_word(8'h01, 1'b0);
    check_result("trunc", 1'b0, 16, 1'b1);
    for (int i = 0; i < 4; i++) send_word(8'h01, 1'b0);
    send_word(8'h01, 1'b1);
    check_result("after_trunc", 1'b1, 5, 1'b0);

    // reset mid-frame discards the partial frame
    send_word(8'h01, 1'b0);
    send_word(8'h02, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_word(8'h07, 1'b1);
    check_result("after_rst", 1'b1, 1, 1'b0);

`ifdef PARITY_CHECK_EN
    par_ready = 1'b0;
    @(posedge clk);
    #1;
    exp_par = 1'b1;
    send_word(8'h03, 1'b1);
    check("par_err_1", {31'd0, par_err}, 32'd1);
    par_ready = 1'b1;
    @(posedge clk);
    #1;
    par_ready = 1'b0;
    exp_par = 1'b0;
    send_word(8'h03, 1'b1);
    check("par_err_0", {31'd0, par_err}, 32'd0);
    par_ready = 1'b1;
`endif

    // random valid/ready traffic, last on every 4th accepted word
    base = m_accepted;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 255));
      in_last   = ((m_accepted - base) % 4 == 3);
      par_ready = 1'($urandom_range(0, 1));
    end

    // drain
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    par_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain_queue", exp_q.size(), 32'd0);
    check("random_words_seen", (m_accepted - base) > 50, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
